// File: rtl/dsp_p_round_sat_if.sv
// Handshake and data bundle between the DSP P outputs, the round/saturate
// stage and its downstream consumer.
interface dsp_p_round_sat_if #(
    parameter int unsigned C_OWIDTH = 16
);
    logic                I_valid;
    logic [47:0]         I_data_p_re;
    logic [47:0]         I_data_p_im;
    logic                I_ready;
    logic                I_stat_clr;
    logic                O_valid;
    logic [C_OWIDTH-1:0] O_data_re;
    logic [C_OWIDTH-1:0] O_data_im;
    logic                O_sat;
    logic [15:0]         O_sat_cnt;
    logic                O_overflow;

    modport slave (
        input  I_valid, I_data_p_re, I_data_p_im, I_ready, I_stat_clr,
        output O_valid, O_data_re, O_data_im, O_sat, O_sat_cnt, O_overflow
    );

    modport master (
        output I_valid, I_data_p_re, I_data_p_im, I_ready, I_stat_clr,
        input  O_valid, O_data_re, O_data_im, O_sat, O_sat_cnt, O_overflow
    );
endinterface

// File: rtl/dsp_p_round_sat.sv
// Aligns DSP48 P results with their issue tag, rounds and saturates both
// components, and buffers them in a first-word-fall-through FIFO.
module dsp_p_round_sat #(
    parameter int unsigned C_OWIDTH     = 16,
    parameter int unsigned C_SHIFT      = 30,
    parameter int unsigned C_RND_MODE   = 2,
    parameter int unsigned C_LATENCY    = 4,
    parameter int unsigned C_FIFO_DEPTH = 4
) (
    input logic               I_clk,
    input logic               I_rst_n,
    dsp_p_round_sat_if.slave  bus
);
    localparam int unsigned RW = 49 - C_SHIFT;
    localparam int unsigned AW = $clog2(C_FIFO_DEPTH);
    localparam int unsigned CW = AW + 1;
    localparam logic [48:0] HALF = 49'(1) << (C_SHIFT - 1);
    localparam logic signed [48:0] SMAX = (49'sd1 <<< (C_OWIDTH - 1)) - 49'sd1;
    localparam logic signed [48:0] SMIN = -(49'sd1 <<< (C_OWIDTH - 1));

    // Tag marking the cycle in which the issued operands' P pair is present
    logic tag;
    generate
        if (C_LATENCY == 0) begin : g_nodly
            assign tag = bus.I_valid;
        end else begin : g_dly
            logic [C_LATENCY-1:0] vld_d;
            always_ff @(posedge I_clk) begin
                if (!I_rst_n) vld_d <= '0;
                else          vld_d <= (vld_d << 1) | C_LATENCY'(bus.I_valid);
            end
            assign tag = vld_d[C_LATENCY-1];
        end
    endgenerate

    function automatic logic [RW-1:0] round_p(input logic [47:0] p);
        logic [48:0] ext;
        logic [48:0] rnd;
        ext = {p[47], p};
        case (C_RND_MODE)
            0:       rnd = '0;
            1:       rnd = HALF;
            default: rnd = HALF - 49'(1) + 49'(ext[C_SHIFT]);
        endcase
        return RW'((ext + rnd) >> C_SHIFT);
    endfunction

    // Returns {clamp_flag, saturated_value}
    function automatic logic [C_OWIDTH:0] sat_r(input logic [RW-1:0] r);
        logic signed [48:0] ext;
        ext = 49'($signed(r));
        if (ext > SMAX)      return {1'b1, SMAX[C_OWIDTH-1:0]};
        else if (ext < SMIN) return {1'b1, SMIN[C_OWIDTH-1:0]};
        else                 return {1'b0, ext[C_OWIDTH-1:0]};
    endfunction

    logic                s1_valid;
    logic [RW-1:0]       s1_re, s1_im;
    logic                s2_valid, s2_sat;
    logic [C_OWIDTH-1:0] s2_re, s2_im;
    logic [C_OWIDTH:0]   sr_c, si_c;

    assign sr_c = sat_r(s1_re);
    assign si_c = sat_r(s1_im);

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            s1_valid <= 1'b0;
            s1_re    <= '0;
            s1_im    <= '0;
            s2_valid <= 1'b0;
            s2_sat   <= 1'b0;
            s2_re    <= '0;
            s2_im    <= '0;
        end else begin
            s1_valid <= tag;
            s1_re    <= round_p(bus.I_data_p_re);
            s1_im    <= round_p(bus.I_data_p_im);
            s2_valid <= s1_valid;
            s2_sat   <= sr_c[C_OWIDTH] | si_c[C_OWIDTH];
            s2_re    <= sr_c[C_OWIDTH-1:0];
            s2_im    <= si_c[C_OWIDTH-1:0];
        end
    end

    logic [C_OWIDTH-1:0] mem_re  [C_FIFO_DEPTH];
    logic [C_OWIDTH-1:0] mem_im  [C_FIFO_DEPTH];
    logic                mem_sat [C_FIFO_DEPTH];
    logic [AW-1:0]       wr_ptr, rd_ptr;
    logic [CW-1:0]       count;
    logic [15:0]         sat_cnt;
    logic                overflow;
    logic                head_c, full_c, pop_c, push_c, drop_c;

    assign head_c = (count != '0);
    assign full_c = (count == CW'(C_FIFO_DEPTH));
    assign pop_c  = head_c & bus.I_ready;
    // A pop in the same cycle frees the slot a full FIFO needs
    assign push_c = s2_valid & (~full_c | pop_c);
    assign drop_c = s2_valid & full_c & ~pop_c;

    always_ff @(posedge I_clk) begin
        if (push_c) begin
            mem_re[wr_ptr]  <= s2_re;
            mem_im[wr_ptr]  <= s2_im;
            mem_sat[wr_ptr] <= s2_sat;
        end
    end

    always_ff @(posedge I_clk) begin
        if (!I_rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_c) wr_ptr <= wr_ptr + AW'(1);
            if (pop_c)  rd_ptr <= rd_ptr + AW'(1);
            if (push_c && !pop_c)      count <= count + CW'(1);
            else if (pop_c && !push_c) count <= count - CW'(1);
        end
    end

    // Statistics; clear wins over a same-cycle increment or overflow
    always_ff @(posedge I_clk) begin
        if (!I_rst_n || bus.I_stat_clr) begin
            sat_cnt  <= '0;
            overflow <= 1'b0;
        end else begin
            if (push_c && s2_sat && sat_cnt != 16'hFFFF) sat_cnt <= sat_cnt + 16'd1;
            if (drop_c) overflow <= 1'b1;
        end
    end

    assign bus.O_valid    = head_c;
    assign bus.O_data_re  = head_c ? mem_re[rd_ptr] : '0;
    assign bus.O_data_im  = head_c ? mem_im[rd_ptr] : '0;
    assign bus.O_sat      = head_c ? mem_sat[rd_ptr] : 1'b0;
    assign bus.O_sat_cnt  = sat_cnt;
    assign bus.O_overflow = overflow;
endmodule

// File: tb/tb_dsp_p_round_sat.sv
// Scoreboard bench: three instances (rounding modes 0/1/2) share stimulus;
// expected samples are queued at issue and compared as the FIFO pops.
module tb_dsp_p_round_sat;
    localparam int unsigned LAT = 4;

    typedef struct {
        longint re;
        longint im;
    } smp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        valid, ready, stat_clr;
    logic [47:0] pre, pim;
    longint      dre [LAT+1];
    longint      dim [LAT+1];
    smp_t        q[$];
    int          total = 0;
    int          bad   = 0;

    always #5 clk = ~clk;

    dsp_p_round_sat_if #(.C_OWIDTH(16)) bus0 ();
    dsp_p_round_sat_if #(.C_OWIDTH(16)) bus1 ();
    dsp_p_round_sat_if #(.C_OWIDTH(16)) bus2 ();

    assign bus0.I_valid = valid;  assign bus1.I_valid = valid;  assign bus2.I_valid = valid;
    assign bus0.I_data_p_re = pre; assign bus1.I_data_p_re = pre; assign bus2.I_data_p_re = pre;
    assign bus0.I_data_p_im = pim; assign bus1.I_data_p_im = pim; assign bus2.I_data_p_im = pim;
    assign bus0.I_ready = ready;  assign bus1.I_ready = ready;  assign bus2.I_ready = ready;
    assign bus0.I_stat_clr = stat_clr; assign bus1.I_stat_clr = stat_clr; assign bus2.I_stat_clr = stat_clr;

    dsp_p_round_sat #(.C_RND_MODE(0)) dut0 (.I_clk(clk), .I_rst_n(rst_n), .bus(bus0));
    dsp_p_round_sat #(.C_RND_MODE(1)) dut1 (.I_clk(clk), .I_rst_n(rst_n), .bus(bus1));
    dsp_p_round_sat #(.C_RND_MODE(2)) dut2 (.I_clk(clk), .I_rst_n(rst_n), .bus(bus2));

    task automatic check(input string tag, input longint got, input longint exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
        end
    endtask

    // Reference: divide by 2^30 with the selected rounding, then clamp to 16 bits
    function automatic void rnd_sat(input longint p, input int mode, output longint r, output bit sat);
        longint half, f, rem;
        half = 64'sd1 <<< 29;
        f    = p >>> 30;
        rem  = p - (f <<< 30);
        if (mode == 1 && rem >= half) f++;
        if (mode == 2 && (rem > half || (rem == half && (f & 64'sd1) != 0))) f++;
        sat = 1'b0;
        r   = f;
        if (f > 32767)  begin r = 32767;  sat = 1'b1; end
        if (f < -32768) begin r = -32768; sat = 1'b1; end
    endfunction

    task automatic cmp_out(input int mode, input logic v, input logic [15:0] re,
                           input logic [15:0] im, input logic sat, input smp_t s);
        longint er, ei;
        bit     sr, si;
        rnd_sat(s.re, mode, er, sr);
        rnd_sat(s.im, mode, ei, si);
        check($sformatf("m%0d_valid", mode), longint'(v), 1);
        check($sformatf("m%0d_re", mode), longint'($signed(re)), er);
        check($sformatf("m%0d_im", mode), longint'($signed(im)), ei);
        check($sformatf("m%0d_sat", mode), longint'(sat), longint'(sr | si));
    endtask

    // Output monitor: every accepted head must match the oldest queued sample
    always @(negedge clk) begin
        if (rst_n && ready && bus2.O_valid) begin
            if (q.size() == 0) begin
                check("spurious_valid", 1, 0);
            end else begin
                smp_t s;
                s = q.pop_front();
                cmp_out(0, bus0.O_valid, bus0.O_data_re, bus0.O_data_im, bus0.O_sat, s);
                cmp_out(1, bus1.O_valid, bus1.O_data_re, bus1.O_data_im, bus1.O_sat, s);
                cmp_out(2, bus2.O_valid, bus2.O_data_re, bus2.O_data_im, bus2.O_sat, s);
            end
        end
    end

    // One clock of stimulus; P data trails its valid by LAT cycles
    task automatic drive(input bit v, input longint re, input longint im, input bit keep);
        smp_t s;
        @(posedge clk);
        #1;
        for (int i = LAT; i > 0; i--) begin
            dre[i] = dre[i-1];
            dim[i] = dim[i-1];
        end
        dre[0] = re;
        dim[0] = im;
        valid  = v;
        pre    = 48'(dre[LAT]);
        pim    = 48'(dim[LAT]);
        if (v && keep) begin
            s.re = re;
            s.im = im;
            q.push_back(s);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) drive(1'b0, 0, 0, 1'b0);
    endtask

    task automatic wait_drain(input string tag, input int limit);
        for (int i = 0; i < limit && q.size() != 0; i++) idle(1);
        check(tag, longint'(q.size()), 0);
    endtask

    task automatic check_zero_outputs(input string tag);
        @(negedge clk);
        check({tag, "_valid"}, longint'(bus2.O_valid), 0);
        check({tag, "_re"}, longint'(bus2.O_data_re), 0);
        check({tag, "_im"}, longint'(bus2.O_data_im), 0);
        check({tag, "_sat"}, longint'(bus2.O_sat), 0);
        check({tag, "_cnt"}, longint'(bus2.O_sat_cnt), 0);
        check({tag, "_ovf"}, longint'(bus2.O_overflow), 0);
    endtask

    function automatic longint rnd_p();
        longint r;
        r = {$urandom, $urandom};
        return r >>> 17;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, first, last, nval;
        rst_n = 1'b0; valid = 1'b0; ready = 1'b1; stat_clr = 1'b0;
        pre = '0; pim = '0;
        for (int i = 0; i <= LAT; i++) begin dre[i] = 0; dim[i] = 0; end
        idle(3);
        check_zero_outputs("reset");
        idle(1);
        rst_n = 1'b1;
        idle(2);

        // Rounding: +-2.5, +-3.5, 1.5/-0.5 in units of 2^30
        drive(1'b1, 64'sd5 <<< 29, -(64'sd5 <<< 29), 1'b1);
        drive(1'b1, 64'sd7 <<< 29, -(64'sd7 <<< 29), 1'b1);
        drive(1'b1, 64'sd3 <<< 29, -(64'sd1 <<< 29), 1'b1);
        wait_drain("round_drain", 30);

        // Saturation, then an in-range sample
        drive(1'b1, 64'sd40000 <<< 30, -(64'sd40000 <<< 30), 1'b1);
        drive(1'b1, 64'sd100 <<< 30, -(64'sd100 <<< 30), 1'b1);
        wait_drain("sat_drain", 30);
        @(negedge clk);
        check("sat_cnt_1", longint'(bus2.O_sat_cnt), 1);

        // Latency from a single issue to first O_valid
        idle(3);
        drive(1'b1, 64'sd9 <<< 30, 64'sd9 <<< 30, 1'b1);
        n = 0;
        @(negedge clk);
        while (!bus2.O_valid && n < 20) begin
            idle(1);
            n++;
            @(negedge clk);
        end
        check("latency", longint'(n), 7);
        wait_drain("lat_drain", 30);

        // Full-throughput burst of 20 random samples
        first = -1; last = -1; nval = 0;
        for (int i = 0; i < 40; i++) begin
            if (i < 20) drive(1'b1, rnd_p(), rnd_p(), 1'b1);
            else        idle(1);
            @(negedge clk);
            if (bus2.O_valid) begin
                if (first < 0) first = i;
                last = i;
                nval++;
            end
        end
        check("burst_count", longint'(nval), 20);
        check("burst_first", longint'(first), 7);
        check("burst_span", longint'(last - first), 19);
        check("burst_drain", longint'(q.size()), 0);

        // Clear statistics before the overflow scenario
        idle(1); stat_clr = 1'b1;
        idle(1); stat_clr = 1'b0;
        @(negedge clk);
        check("clr_cnt", longint'(bus2.O_sat_cnt), 0);

        // Backpressure: 4 fit, samples 5 and 6 are dropped
        idle(1); ready = 1'b0;
        drive(1'b1, 64'sd40000 <<< 30, 64'sd11 <<< 30, 1'b1);
        drive(1'b1, 64'sd12 <<< 30, -(64'sd12 <<< 30), 1'b1);
        drive(1'b1, 64'sd13 <<< 30, -(64'sd13 <<< 30), 1'b1);
        drive(1'b1, 64'sd14 <<< 30, -(64'sd14 <<< 30), 1'b1);
        idle(10);
        @(negedge clk);
        check("full_no_ovf", longint'(bus2.O_overflow), 0);
        check("full_valid", longint'(bus2.O_valid), 1);
        drive(1'b1, -(64'sd40000 <<< 30), 64'sd15 <<< 30, 1'b0);
        drive(1'b1, 64'sd16 <<< 30, 64'sd16 <<< 30, 1'b0);
        idle(10);
        @(negedge clk);
        check("ovf_set", longint'(bus2.O_overflow), 1);
        check("drop_no_cnt", longint'(bus2.O_sat_cnt), 1);
        ready = 1'b1;
        wait_drain("ovf_drain", 20);
        idle(2);
        @(negedge clk);
        check("ovf_empty", longint'(bus2.O_valid), 0);
        idle(1); stat_clr = 1'b1;
        idle(1); stat_clr = 1'b0;
        @(negedge clk);
        check("stat_clr_ovf", longint'(bus2.O_overflow), 0);
        check("stat_clr_cnt", longint'(bus2.O_sat_cnt), 0);

        // Full FIFO with a pop in the same cycle as the write
        ready = 1'b0;
        for (int i = 0; i < 4; i++) drive(1'b1, longint'(20 + i) <<< 30, -(longint'(20 + i) <<< 30), 1'b1);
        idle(10);
        drive(1'b1, 64'sd30 <<< 30, 64'sd31 <<< 30, 1'b1);
        idle(6);
        ready = 1'b1;
        idle(1);
        ready = 1'b0;
        idle(3);
        @(negedge clk);
        check("simul_no_ovf", longint'(bus2.O_overflow), 0);
        check("simul_valid", longint'(bus2.O_valid), 1);
        ready = 1'b1;
        wait_drain("simul_drain", 20);

        // Reset with 2 buffered and 3 in flight
        idle(1); ready = 1'b0;
        drive(1'b1, 64'sd40000 <<< 30, 64'sd1 <<< 30, 1'b1);
        drive(1'b1, 64'sd2 <<< 30, 64'sd2 <<< 30, 1'b1);
        idle(10);
        @(negedge clk);
        check("pre_rst_cnt", longint'(bus2.O_sat_cnt), 1);
        drive(1'b1, 64'sd3 <<< 30, 64'sd3 <<< 30, 1'b1);
        drive(1'b1, 64'sd4 <<< 30, 64'sd4 <<< 30, 1'b1);
        drive(1'b1, 64'sd5 <<< 30, 64'sd5 <<< 30, 1'b1);
        idle(1);
        rst_n = 1'b0;
        q.delete();
        idle(1);
        rst_n = 1'b1;
        check_zero_outputs("midrst");
        ready = 1'b1;
        idle(20);
        check("midrst_empty", longint'(q.size()), 0);
        @(negedge clk);
        check("midrst_idle", longint'(bus2.O_valid), 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/dsp_p_round_sat.md
Name: dsp_p_round_sat

Overview:
- Downstream stage of the DSP48 multiply-accumulate slices in the complex multiplier datapath.
- Takes the two 48-bit P results (real and imaginary) and aligns them with a valid tag delayed to match the DSP pipeline.
- Rounds each result to C_OWIDTH bits after dropping C_SHIFT fractional LSBs, then saturates it.
- Buffers results in a small FIFO with a valid/ready output, because the DSP slices cannot be stalled.

Parameters:
C_OWIDTH, 16, output sample width per component (2..32)
C_SHIFT, 30, number of P LSBs discarded (1..40)
C_RND_MODE, 2, 0 = truncate (floor), 1 = round half up, 2 = convergent (round half to even)
C_LATENCY, 4, cycles from I_valid to the matching P on I_data_p_re/im (0..8)
C_FIFO_DEPTH, 4, output FIFO entries (power of two, 2..16)

Ports:
I_clk  input  1  clock
I_rst_n  input  1  synchronous active-low reset
I_valid  input  1  high in the cycle operands are issued to the DSP slices
I_data_p_re  input  48  real P output of DSP slice, signed
I_data_p_im  input  48  imaginary P output of DSP slice, signed
I_ready  input  1  downstream accepts O_data when high with O_valid
I_stat_clr  input  1  clears O_sat_cnt and O_overflow
O_valid  output  1  FIFO head valid
O_data_re  output  C_OWIDTH  rounded/saturated real part
O_data_im  output  C_OWIDTH  rounded/saturated imaginary part
O_sat  output  1  head sample had a saturated component
O_sat_cnt  output  16  saturation event counter, sticks at 16'hFFFF
O_overflow  output  1  sticky: a sample was dropped because the FIFO was full

Behaviour:
- Reset: while I_rst_n=0 at a clock edge, the following are cleared:
  - the valid delay line, both pipeline stages, and FIFO pointers and count
  - O_sat_cnt and O_overflow
- Reset outputs: O_valid=0, O_data_re=0, O_data_im=0, O_sat=0, O_sat_cnt=0, O_overflow=0.
- Reset mid-operation discards every in-flight and buffered sample. No partial output appears after reset is released.
- Alignment: an I_valid sampled at edge t marks the P pair present on the ports in cycle t+C_LATENCY. A C_LATENCY-deep shift register does this; C_LATENCY=0 means same cycle.
- Stage 1 (registered) rounds each component in 49-bit signed arithmetic (sign-extend P first) and keeps bits [48:C_SHIFT]:
  - mode 0: add 0
  - mode 1: add 2^(C_SHIFT-1)
  - mode 2: add 2^(C_SHIFT-1)-1+P[C_SHIFT]
- Stage 2 (registered) saturates:
  - results above 2^(C_OWIDTH-1)-1 clamp to that maximum; results below -2^(C_OWIDTH-1) clamp to that minimum.
  - The sample's sat bit is the OR of both component clamp flags.
- FIFO write: the stage-2 result is written the cycle after stage 2 is valid.
- FIFO is first-word-fall-through. O_valid, O_data_*, O_sat reflect the head.
  - Total latency from the accepted-operand edge to O_valid with an empty FIFO is C_LATENCY+3 cycles.
- Pop when O_valid & I_ready. Head data stays stable while O_valid=1 and I_ready=0.
- Simultaneous write and pop when full: the pop frees the slot, the write succeeds, no overflow.
- Write when full without a pop: the sample is dropped and O_overflow is set. A dropped sample does not increment O_sat_cnt.
- O_sat_cnt increments by 1 per sample written with sat=1 and holds at 16'hFFFF.
- I_stat_clr has priority over a same-cycle increment or overflow set: the result is 0.
- Back-to-back I_valid every cycle is supported at full throughput when I_ready=1.

Test Plan:
- Defaults for all scenarios: OW=16, SHIFT=30, LATENCY=4.
- Rounding: P_re=2.5·2^30, P_im=-2.5·2^30.
  - mode 0 → (2, -3)
  - mode 1 → (3, -2)
  - mode 2 → (2, -2)
  - P_re=3.5·2^30 in mode 2 → 4
- Saturation: P_re=40000·2^30, P_im=-40000·2^30 → O_data_re=32767, O_data_im=-32768, O_sat=1, O_sat_cnt=1. A following P=100·2^30 → 100, O_sat=0.
- Latency/throughput: I_valid pulse at cycle 10 with I_ready=1 → O_valid first high at cycle 17. Then 20 consecutive I_valid cycles → 20 consecutive outputs, in order, no gaps.
- Backpressure/overflow (FIFO depth 4): I_ready=0, send 6 samples.
  - Result: 4 buffered, O_overflow=1 after the 5th write.
  - Release I_ready: exactly samples 1..4 emerge in order, then O_valid=0.
  - Pulse I_stat_clr → O_overflow=0, O_sat_cnt=0.
- Full with simultaneous pop: FIFO full and I_ready=1 while a new sample arrives → no overflow, count stays 4.
- Reset mid-operation: drive I_rst_n=0 for 1 cycle with 3 samples in flight and 2 buffered → all outputs 0 the next cycle, and no stale sample appears afterwards.
